// File: rtl/t5_hsch_pkg.sv
// Shared types and constants for the t5 hart scheduler.
package t5_hsch_pkg;

  // Largest supported hart count; hart IDs never need more than 4 bits.
  localparam int NHART_MAX = 16;
  localparam int HID_MAX_W = 4;

  // Result of a round-robin search: whether a hart was found and which one.
  typedef struct packed {
    logic                 found;
    logic [HID_MAX_W-1:0] id;
  } pick_t;

  // Hart-ID width for a given hart count (at least one bit).
  function automatic int hw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Round-robin pointer value after reset, chosen so hart 0 issues first.
  function automatic int ptr_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/t5_hsch_if.sv
// Pipeline-control and data-bus handshake bundle between t5_sysc and the
// hart scheduler. Clock and reset stay outside as plain ports.
interface t5_hsch_if
  import t5_hsch_pkg::*;
#(
  parameter int NHART = 4
) ();
  localparam int HW = hw_of(NHART);

  logic             sena;
  logic [NHART-1:0] hrun;
  logic             xreq;
  logic             dwb_ack;

  logic [HW-1:0]    fhart;
  logic [HW-1:0]    dhart;
  logic [HW-1:0]    xhart;
  logic [HW-1:0]    mhart;
  logic             fvld;
  logic             dvld;
  logic             xvld;
  logic             mvld;
  logic [NHART-1:0] hwait;
  logic             herr;

  // System side: drives enables and bus status, observes the schedule.
  modport master (
    output sena, hrun, xreq, dwb_ack,
    input  fhart, dhart, xhart, mhart, fvld, dvld, xvld, mvld, hwait, herr
  );

  // Scheduler side.
  modport slave (
    input  sena, hrun, xreq, dwb_ack,
    output fhart, dhart, xhart, mhart, fvld, dvld, xvld, mvld, hwait, herr
  );

endinterface

// File: rtl/t5_hsch_hfifo.sv
// In-order ID FIFO: remembers which hart owns each outstanding data request
// so acknowledges can be matched back to harts in issue order.
module t5_hfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int             PW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int             CW   = PW + 1;
  localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;

  // Next pointers and occupancy; pointers wrap at DEPTH-1 for any depth.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of block ordering.
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, and the occupancy counter guards that.
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/t5_hsch.sv
// Round-robin hart scheduler: picks the next hart for fetch, skipping harts
// that are parked, already in fetch/decode/execute, or waiting on a data-bus
// acknowledge, and carries hart tags and valid bits down to the memory stage.
module t5_hsch
  import t5_hsch_pkg::*;
#(
  parameter int NHART = 4
) (
  input logic        sclk,
  input logic        srst,
  t5_hsch_if.slave   bus
);
  localparam int            HW      = hw_of(NHART);
  localparam logic [HW-1:0] PTR_RST = HW'(ptr_reset(NHART));

  logic [HW-1:0]    fhart_q, fhart_d, dhart_q, dhart_d;
  logic [HW-1:0]    xhart_q, xhart_d, mhart_q, mhart_d;
  logic             fvld_q, fvld_d, dvld_q, dvld_d;
  logic             xvld_q, xvld_d, mvld_q, mvld_d;
  logic [HW-1:0]    ptr_q, ptr_d;
  logic [NHART-1:0] hwait_q, hwait_d;
  logic             herr_q, herr_d;
  logic [NHART-1:0] busy;
  logic [NHART-1:0] elig;
  pick_t            pick;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [HW-1:0]    fifo_head;

  // First eligible hart strictly after ptr, wrapping at NHART-1, so IDs at
  // or above NHART can never be produced.
  function automatic pick_t rr_pick(input logic [NHART-1:0] el,
                                    input logic [HW-1:0]    ptr);
    pick_t r;
    int    idx;
    r = '0;
    for (int i = 1; i <= NHART; i++) begin
      idx = (int'(ptr) + i) % NHART;
      if (!r.found && el[idx[HW-1:0]]) begin
        r.found = 1'b1;
        r.id    = HID_MAX_W'(idx);
      end
    end
    return r;
  endfunction

  // Eligibility: running, not waiting, and not already in f/d/x. The memory
  // stage is excluded so a hart can be re-issued as it leaves execute.
  always_comb begin
    busy = '0;
    if (fvld_q) busy[fhart_q] = 1'b1;
    if (dvld_q) busy[dhart_q] = 1'b1;
    if (xvld_q) busy[xhart_q] = 1'b1;
    elig = bus.hrun & ~hwait_q & ~busy;
    pick = rr_pick(elig, ptr_q);
  end

  // Tag pipeline and issue: everything holds while sena is low; with no
  // eligible hart a bubble enters fetch and fhart keeps its last value.
  always_comb begin
    fhart_d = fhart_q;
    dhart_d = dhart_q;
    xhart_d = xhart_q;
    mhart_d = mhart_q;
    fvld_d  = fvld_q;
    dvld_d  = dvld_q;
    xvld_d  = xvld_q;
    mvld_d  = mvld_q;
    ptr_d   = ptr_q;
    if (bus.sena) begin
      dhart_d = fhart_q;
      dvld_d  = fvld_q;
      xhart_d = dhart_q;
      xvld_d  = dvld_q;
      mhart_d = xhart_q;
      mvld_d  = xvld_q;
      fvld_d  = pick.found;
      if (pick.found) begin
        fhart_d = pick.id[HW-1:0];
        ptr_d   = pick.id[HW-1:0];
      end
    end
  end

  // Requests are only taken on enabled edges; acks are honoured regardless
  // of sena because t5_sysc holds sena low while waiting for them.
  assign push = bus.sena & xvld_q & bus.xreq;
  assign pop  = bus.dwb_ack & ~fifo_empty;

  // Wait mask and sticky error; a same-hart set and clear resolves to set.
  always_comb begin
    hwait_d = hwait_q;
    if (pop)  hwait_d[fifo_head] = 1'b0;
    if (push) hwait_d[xhart_q]   = 1'b1;
    herr_d = herr_q | (bus.dwb_ack & fifo_empty);
  end

  // Scheduler state registers.
  always_ff @(posedge sclk) begin
    if (srst) begin
      fhart_q <= '0;
      dhart_q <= '0;
      xhart_q <= '0;
      mhart_q <= '0;
      fvld_q  <= 1'b0;
      dvld_q  <= 1'b0;
      xvld_q  <= 1'b0;
      mvld_q  <= 1'b0;
      ptr_q   <= PTR_RST;
      hwait_q <= '0;
      herr_q  <= 1'b0;
    end else begin
      fhart_q <= fhart_d;
      dhart_q <= dhart_d;
      xhart_q <= xhart_d;
      mhart_q <= mhart_d;
      fvld_q  <= fvld_d;
      dvld_q  <= dvld_d;
      xvld_q  <= xvld_d;
      mvld_q  <= mvld_d;
      ptr_q   <= ptr_d;
      hwait_q <= hwait_d;
      herr_q  <= herr_d;
    end
  end

  t5_hfifo #(
    .DEPTH (NHART),
    .W     (HW)
  ) u_hfifo (
    .clk     (sclk),
    .rst     (srst),
    .push_i  (push),
    .din_i   (xhart_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // A waiting hart is never re-issued, so the FIFO cannot be full on a push.
  a_no_overflow: assert property (@(posedge sclk) disable iff (srst)
                                  !(push && fifo_full));

  assign bus.fhart = fhart_q;
  assign bus.dhart = dhart_q;
  assign bus.xhart = xhart_q;
  assign bus.mhart = mhart_q;
  assign bus.fvld  = fvld_q;
  assign bus.dvld  = dvld_q;
  assign bus.xvld  = xvld_q;
  assign bus.mvld  = mvld_q;
  assign bus.hwait = hwait_q;
  assign bus.herr  = herr_q;

endmodule

// File: tb/tb_t5_hsch.sv
// Bench for t5_hsch: a 4-hart and a 3-hart scheduler share one stimulus
// stream and are compared against a queue-based reference model.
module tb_t5_hsch;

  logic       sclk;
  logic       srst;
  logic       sena;
  logic [3:0] hrun;
  logic       xreq;
  logic       ack;

  int n_tests = 0;
  int n_fail  = 0;

  t5_hsch_if #(.NHART(4)) if4 ();
  t5_hsch_if #(.NHART(3)) if3 ();

  assign if4.sena    = sena;
  assign if4.hrun    = hrun;
  assign if4.xreq    = xreq;
  assign if4.dwb_ack = ack;
  assign if3.sena    = sena;
  assign if3.hrun    = hrun[2:0];
  assign if3.xreq    = xreq;
  assign if3.dwb_ack = ack;

  t5_hsch #(.NHART(4)) dut4 (.sclk(sclk), .srst(srst), .bus(if4));
  t5_hsch #(.NHART(3)) dut3 (.sclk(sclk), .srst(srst), .bus(if3));

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Packed view of each DUT, fetch tag first, herr last.
  logic [31:0] obs4, obs3;
  assign obs4 = {15'b0, if4.fhart, if4.fvld, if4.dhart, if4.dvld, if4.xhart,
                 if4.xvld, if4.mhart, if4.mvld, if4.hwait, if4.herr};
  assign obs3 = {16'b0, if3.fhart, if3.fvld, if3.dhart, if3.dvld, if3.xhart,
                 if3.xvld, if3.mhart, if3.mvld, if3.hwait, if3.herr};

  // Reference model: slot 0..3 = fetch..memory, plus a queue of waiting harts.
  int m_tag  [2][4];
  bit m_vld  [2][4];
  int m_ptr  [2];
  bit m_wait [2][16];
  bit m_err  [2];
  int q0[$];
  int q1[$];

  task automatic model_reset(input int k, input int nh);
    for (int s = 0; s < 4; s++) begin m_tag[k][s] = 0; m_vld[k][s] = 0; end
    for (int h = 0; h < 16; h++) m_wait[k][h] = 0;
    m_ptr[k] = nh - 1;
    m_err[k] = 0;
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  task automatic model_step(input int k, input int nh);
    int  pick, h, xt, qn;
    bit  xv, inflight;
    xt = m_tag[k][2];
    xv = m_vld[k][2];
    if (sena) begin
      pick = -1;
      for (int i = 1; i <= nh && pick < 0; i++) begin
        h = (m_ptr[k] + i) % nh;
        inflight = 0;
        for (int s = 0; s < 3; s++)
          if (m_vld[k][s] && m_tag[k][s] == h) inflight = 1;
        if (hrun[h] && !m_wait[k][h] && !inflight) pick = h;
      end
      for (int s = 3; s > 0; s--) begin
        m_tag[k][s] = m_tag[k][s-1];
        m_vld[k][s] = m_vld[k][s-1];
      end
      m_vld[k][0] = (pick >= 0);
      if (pick >= 0) begin m_tag[k][0] = pick; m_ptr[k] = pick; end
    end
    qn = (k == 0) ? q0.size() : q1.size();
    if (ack) begin
      if (qn > 0) begin
        h = (k == 0) ? q0.pop_front() : q1.pop_front();
        m_wait[k][h] = 0;
      end else m_err[k] = 1;
    end
    if (sena && xv && xreq) begin
      if (k == 0) q0.push_back(xt); else q1.push_back(xt);
      m_wait[k][xt] = 1;
    end
  endtask

  function automatic logic [31:0] exp_vec(input int k, input int nh);
    logic [31:0] v;
    v = '0;
    for (int s = 0; s < 4; s++) begin
      v = (v << 2) | 32'(m_tag[k][s] & 3);
      v = (v << 1) | 32'(m_vld[k][s]);
    end
    for (int h = nh - 1; h >= 0; h--) v = (v << 1) | 32'(m_wait[k][h]);
    v = (v << 1) | 32'(m_err[k]);
    return v;
  endfunction

  // One clock: model advances on the edge, outputs are sampled at negedge.
  task automatic cycle();
    @(posedge sclk);
    if (!srst) begin model_step(0, 4); model_step(1, 3); end
    @(negedge sclk);
  endtask

  task automatic do_reset();
    srst = 1'b1; sena = 1'b0; hrun = '0; xreq = 1'b0; ack = 1'b0;
    cycle(); cycle();
    model_reset(0, 4); model_reset(1, 3);
    srst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (obs4 !== 32'h0) begin
      n_fail++; $display("FAIL reset4: got %h want %h", obs4, 32'h0);
    end
    n_tests++;
    if (obs3 !== 32'h0) begin
      n_fail++; $display("FAIL reset3: got %h want %h", obs3, 32'h0);
    end
  endtask

  task automatic test_rotation();
    int hist[$];
    do_reset();
    hrun = 4'hF; sena = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      hist.push_back(int'(if4.fhart));
      n_tests++;
      if (if4.fvld !== 1'b1 || int'(if4.fhart) != c % 4) begin
        n_fail++;
        $display("FAIL rotation c%0d: got v%b h%0d want v1 h%0d", c, if4.fvld, if4.fhart, c % 4);
      end
      if (c >= 3) begin
        n_tests++;
        if (if4.mvld !== 1'b1 || int'(if4.mhart) != hist[c-3]) begin
          n_fail++;
          $display("FAIL mem_trail c%0d: got v%b h%0d want v1 h%0d", c, if4.mvld, if4.mhart, hist[c-3]);
        end
      end
      n_tests++;
      if (obs3 !== exp_vec(1, 3)) begin
        n_fail++; $display("FAIL rotation3 c%0d: got %h want %h", c, obs3, exp_vec(1, 3));
      end
    end
  endtask

  task automatic test_sparse();
    bit ev; int eh;
    do_reset();
    hrun = 4'b0101; sena = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cycle();
      ev = (c % 4) < 2;
      eh = (c % 4 == 0) ? 0 : 2;
      n_tests++;
      if (if4.fvld !== ev || (ev && int'(if4.fhart) != eh)) begin
        n_fail++;
        $display("FAIL sparse c%0d: got v%b h%0d want v%b h%0d", c, if4.fvld, if4.fhart, ev, eh);
      end
      n_tests++;
      if (obs4 !== exp_vec(0, 4) || obs3 !== exp_vec(1, 3)) begin
        n_fail++;
        $display("FAIL sparse_model c%0d: got %h/%h want %h/%h", c, obs4, obs3, exp_vec(0, 4), exp_vec(1, 3));
      end
    end
  endtask

  task automatic test_wait();
    bit done, seen;
    do_reset();
    hrun = 4'hF; sena = 1'b1; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      xreq = m_vld[0][2] && m_tag[0][2] == 1;
      cycle();
      if (xreq) done = 1;
      xreq = 1'b0;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL wait_req: got no request want hart 1 in execute"); end
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_tests++;
      if (if4.hwait !== 4'b0010 || (if4.fvld && if4.fhart == 2'd1)) begin
        n_fail++;
        $display("FAIL wait_hold c%0d: got hwait %b f%b/%0d want hwait 0010 no hart1", c, if4.hwait, if4.fvld, if4.fhart);
      end
    end
    ack = 1'b1; cycle(); ack = 1'b0;
    n_tests++;
    if (if4.hwait !== 4'b0000) begin
      n_fail++; $display("FAIL wait_ack: got %b want 0000", if4.hwait);
    end
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      cycle();
      n_tests++;
      if (obs4 !== exp_vec(0, 4)) begin
        n_fail++; $display("FAIL wait_resume c%0d: got %h want %h", c, obs4, exp_vec(0, 4));
      end
      if (if4.fvld && if4.fhart == 2'd1) seen = 1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL wait_refetch: got no fetch want hart 1"); end
  endtask

  task automatic test_fifo_order();
    bit d0, d2;
    do_reset();
    hrun = 4'b0101; sena = 1'b1; d0 = 0; d2 = 0;
    for (int c = 0; c < 30 && !(d0 && d2); c++) begin
      xreq = m_vld[0][2] && ((m_tag[0][2] == 0 && !d0) || (m_tag[0][2] == 2 && d0 && !d2));
      cycle();
      if (xreq && m_tag[0][3] == 0) d0 = 1;
      if (xreq && m_tag[0][3] == 2) d2 = 1;
      xreq = 1'b0;
    end
    n_tests++;
    if (if4.hwait !== 4'b0101) begin
      n_fail++; $display("FAIL fifo_both: got %b want 0101", if4.hwait);
    end
    ack = 1'b1; cycle();
    n_tests++;
    if (if4.hwait !== 4'b0100) begin
      n_fail++; $display("FAIL fifo_first: got %b want 0100", if4.hwait);
    end
    cycle(); ack = 1'b0;
    n_tests++;
    if (if4.hwait !== 4'b0000 || if4.herr !== 1'b0) begin
      n_fail++; $display("FAIL fifo_second: got %b err%b want 0000 err0", if4.hwait, if4.herr);
    end
  endtask

  task automatic test_herr();
    bit done;
    do_reset();
    sena = 1'b1; ack = 1'b1; cycle(); ack = 1'b0;
    n_tests++;
    if (if4.herr !== 1'b1 || if3.herr !== 1'b1) begin
      n_fail++; $display("FAIL herr_set: got %b/%b want 1/1", if4.herr, if3.herr);
    end
    hrun = 4'hF;
    for (int c = 0; c < 5; c++) cycle();
    n_tests++;
    if (if4.herr !== 1'b1) begin n_fail++; $display("FAIL herr_sticky: got %b want 1", if4.herr); end
    do_reset();
    n_tests++;
    if (if4.herr !== 1'b0) begin n_fail++; $display("FAIL herr_clear: got %b want 0", if4.herr); end
    hrun = 4'hF; sena = 1'b1; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      xreq = m_vld[0][2] && m_tag[0][2] == 0;
      cycle();
      if (xreq) done = 1;
      xreq = 1'b0;
    end
    n_tests++;
    if (if4.hwait !== 4'b0001) begin n_fail++; $display("FAIL herr_pend: got %b want 0001", if4.hwait); end
    do_reset();
    sena = 1'b1; ack = 1'b1; cycle(); ack = 1'b0;
    n_tests++;
    if (if4.herr !== 1'b1 || if4.hwait !== 4'b0000) begin
      n_fail++; $display("FAIL herr_after_rst: got err%b %b want err1 0000", if4.herr, if4.hwait);
    end
  endtask

  task automatic test_stall();
    bit done;
    logic [11:0] snap;
    do_reset();
    hrun = 4'hF; sena = 1'b1; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      xreq = m_vld[0][2] && m_tag[0][2] == 3;
      cycle();
      if (xreq) done = 1;
      xreq = 1'b0;
    end
    n_tests++;
    if (if4.hwait !== 4'b1000) begin n_fail++; $display("FAIL stall_pend: got %b want 1000", if4.hwait); end
    snap = obs4[16:5];
    sena = 1'b0;
    for (int s = 0; s < 5; s++) begin
      ack = (s == 2);
      cycle();
      n_tests++;
      if (obs4[16:5] !== snap) begin
        n_fail++; $display("FAIL stall_hold s%0d: got %h want %h", s, obs4[16:5], snap);
      end
    end
    ack = 1'b0;
    n_tests++;
    if (if4.hwait !== 4'b0000) begin n_fail++; $display("FAIL stall_ack: got %b want 0000", if4.hwait); end
    sena = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      n_tests++;
      if (obs4 !== exp_vec(0, 4)) begin
        n_fail++; $display("FAIL stall_resume c%0d: got %h want %h", c, obs4, exp_vec(0, 4));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 16 == 0) hrun = 4'($urandom);
      sena = ($urandom_range(3) != 0);
      xreq = 1'($urandom_range(1));
      ack  = ($urandom_range(3) == 0);
      cycle();
      n_tests++;
      if (obs4 !== exp_vec(0, 4)) begin
        n_fail++; $display("FAIL rand4 c%0d: got %h want %h", c, obs4, exp_vec(0, 4));
      end
      n_tests++;
      if (obs3 !== exp_vec(1, 3)) begin
        n_fail++; $display("FAIL rand3 c%0d: got %h want %h", c, obs3, exp_vec(1, 3));
      end
      n_tests++;
      if (if3.fhart > 2'd2 || if3.dhart > 2'd2 || if3.xhart > 2'd2 || if3.mhart > 2'd2) begin
        n_fail++;
        $display("FAIL rand3_ids c%0d: got %0d %0d %0d %0d want all below 3", c, if3.fhart, if3.dhart, if3.xhart, if3.mhart);
      end
    end
    sena = 1'b0; xreq = 1'b0; ack = 1'b0;
  endtask

  initial begin
    srst = 1'b1; sena = 1'b0; hrun = '0; xreq = 1'b0; ack = 1'b0;
    @(negedge sclk);
    test_reset();
    test_rotation();
    test_sparse();
    test_wait();
    test_fifo_order();
    test_herr();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
